// File: rtl/dual_debouncer.sv
// Two independent switch debouncers: 2-flop synchronizer, 4-state accept FSM,
// registered level output and single-cycle rise/fall pulses per channel.
module dual_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    TO_HIGH = 2'd1,
    HIGH    = 2'd2,
    TO_LOW  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw_vec;
  assign raw_vec = {b_raw, a_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic        s1_reg;
      logic        s2_reg;
      state_t      state_reg;
      state_t      state_next;
      logic [15:0] cnt_reg;
      logic [15:0] cnt_next;
      logic        level_reg;
      logic        level_next;
      logic        rise_reg;
      logic        rise_next;
      logic        fall_reg;
      logic        fall_next;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          state_reg <= LOW;
          cnt_reg   <= 16'd0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          s1_reg    <= raw_vec[gi];
          s2_reg    <= s1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      // Any disagreeing sample during a transition drops straight back to the
      // settled state, so the count always restarts from scratch.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        unique case (state_reg)
          LOW: begin
            if (s2_reg) begin
              state_next = TO_HIGH;
              cnt_next   = 16'd1;
            end else begin
              cnt_next   = 16'd0;
            end
          end
          TO_HIGH: begin
            if (!s2_reg) begin
              state_next = LOW;
              cnt_next   = 16'd0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = HIGH;
              cnt_next   = 16'd0;
              rise_next  = 1'b1;
            end else begin
              cnt_next   = cnt_reg + 16'd1;
            end
          end
          HIGH: begin
            if (!s2_reg) begin
              state_next = TO_LOW;
              cnt_next   = 16'd1;
            end else begin
              cnt_next   = 16'd0;
            end
          end
          TO_LOW: begin
            if (s2_reg) begin
              state_next = HIGH;
              cnt_next   = 16'd0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = LOW;
              cnt_next   = 16'd0;
              fall_next  = 1'b1;
            end else begin
              cnt_next   = cnt_reg + 16'd1;
            end
          end
          default: begin
            state_next = LOW;
            cnt_next   = 16'd0;
          end
        endcase
        level_next = (state_next == HIGH) || (state_next == TO_LOW);
      end
    end
  endgenerate

  assign a      = g_ch[0].level_reg;
  assign a_rise = g_ch[0].rise_reg;
  assign a_fall = g_ch[0].fall_reg;
  assign b      = g_ch[1].level_reg;
  assign b_rise = g_ch[1].rise_reg;
  assign b_fall = g_ch[1].fall_reg;

endmodule

// File: tb/tb_dual_debouncer.sv
// Scoreboard bench for dual_debouncer: stimulus queues expected pulses and
// level probes by edge number; a negedge monitor pops and compares them.
module tb_dual_debouncer;

  localparam int N   = 4;
  localparam int LAT = N + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic a_raw, b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  dual_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit rise;
    int cyc;
  } ev_t;

  typedef struct {
    int cyc;
    bit ea;
    bit eb;
  } probe_t;

  ev_t    exp_q[$];
  probe_t prb_q[$];
  int     cycle_cnt = 0;
  int     checks    = 0;
  int     failures  = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: the only process that steps the counters.
  always @(negedge clk) begin
    ev_t    e;
    probe_t p;
    logic   r, f, lv;
    while (exp_q.size() > 0 && exp_q[0].cyc < cycle_cnt) begin
      e = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL missed_pulse ch=%0d rise=%0b expected at edge %0d, still absent at edge %0d",
               e.ch, e.rise, e.cyc, cycle_cnt);
    end
    while (prb_q.size() > 0 && prb_q[0].cyc < cycle_cnt) begin
      p = prb_q.pop_front();
      checks++; failures++;
      $display("FAIL missed_probe at edge %0d", p.cyc);
    end
    if (prb_q.size() > 0 && prb_q[0].cyc == cycle_cnt) begin
      p = prb_q.pop_front();
      checks++;
      if (a !== p.ea || b !== p.eb || a_rise !== 1'b0 || a_fall !== 1'b0 ||
          b_rise !== 1'b0 || b_fall !== 1'b0) begin
        failures++;
        $display("FAIL level_probe edge=%0d got a=%b b=%b pulses=%b%b%b%b required a=%b b=%b pulses=0000",
                 cycle_cnt, a, b, a_rise, a_fall, b_rise, b_fall, p.ea, p.eb);
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      r  = (ch == 0) ? a_rise : b_rise;
      f  = (ch == 0) ? a_fall : b_fall;
      lv = (ch == 0) ? a : b;
      if (r === 1'b1 && f === 1'b1) begin
        checks++; failures++;
        $display("FAIL both_pulses ch=%0d edge=%0d got rise=1 fall=1 required at most one", ch, cycle_cnt);
      end else if (r === 1'b1 || f === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse ch=%0d rise=%b edge=%0d required no pulse", ch, r, cycle_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.ch != ch || e.rise != r || e.cyc != cycle_cnt || lv !== r) begin
            failures++;
            $display("FAIL pulse ch=%0d rise=%b level=%b edge=%0d required ch=%0d rise=%b level=%b edge=%0d",
                     ch, r, lv, cycle_cnt, e.ch, e.rise, e.rise, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int ch, input bit rise, input int cyc);
    ev_t e;
    e.ch = ch; e.rise = rise; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_probe(input int cyc, input bit ea, input bit eb);
    probe_t p;
    p.cyc = cyc; p.ea = ea; p.eb = eb;
    prb_q.push_back(p);
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() > 0 || prb_q.size() > 0) && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    tick(1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; a_raw = 1'b1; b_raw = 1'b1;
    push_probe(1, 0, 0); push_probe(2, 0, 0); push_probe(3, 0, 0);
    tick(3);

    // Release with both inputs high: both channels debounce a rise.
    rst_n = 1'b1; k = cycle_cnt;
    push_probe(k + LAT - 1, 0, 0);
    push_ev(0, 1, k + LAT); push_ev(1, 1, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 1, 1); drain();

    // A falls alone.
    a_raw = 1'b0; k = cycle_cnt;
    push_ev(0, 0, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 0, 1); drain();

    // Simultaneous A rise and B fall.
    a_raw = 1'b1; b_raw = 1'b0; k = cycle_cnt;
    push_ev(0, 1, k + LAT); push_ev(1, 0, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 1, 0); drain();

    a_raw = 1'b0; k = cycle_cnt;
    push_ev(0, 0, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 0, 0); drain();

    // Single-channel rise on A, B untouched.
    a_raw = 1'b1; k = cycle_cnt;
    push_probe(k + LAT - 1, 0, 0);
    push_ev(0, 1, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 1, 0); drain();
    a_raw = 1'b0; k = cycle_cnt;
    push_ev(0, 0, k + LAT);
    drain();

    // Glitch of N-1 cycles is rejected.
    a_raw = 1'b1; tick(N - 1); a_raw = 1'b0;
    tick(10); push_probe(cycle_cnt + 1, 0, 0); drain();

    // B held exactly N cycles is accepted, then released.
    b_raw = 1'b1; k = cycle_cnt;
    push_ev(1, 1, k + LAT); push_ev(1, 0, k + N + LAT);
    tick(N); b_raw = 1'b0;
    drain(); push_probe(cycle_cnt + 1, 0, 0); drain();

    // Bounce 1,0,1 then hold.
    a_raw = 1'b1; tick(1); a_raw = 1'b0; tick(1); a_raw = 1'b1; k = cycle_cnt;
    push_probe(k + LAT - 1, 0, 0);
    push_ev(0, 1, k + LAT);
    drain(); push_probe(cycle_cnt + 1, 1, 0); drain();
    a_raw = 1'b0; k = cycle_cnt;
    push_ev(0, 0, k + LAT);
    drain();

    // Reset pulse on edge 4 of a pending rise discards progress.
    a_raw = 1'b1; k = cycle_cnt;
    tick(3); rst_n = 1'b0; push_probe(k + 4, 0, 0);
    tick(1); rst_n = 1'b1;
    push_probe(k + 5, 0, 0); push_probe(k + 4 + LAT - 1, 0, 0);
    push_ev(0, 1, k + 4 + LAT);
    drain(); push_probe(cycle_cnt + 1, 1, 0); drain();

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
